ch8_accum_sat: RTL and testbench

- 8-channel signed frame accumulator that sits directly downstream of the 8-lane signed adder in ip_fdt.
- Sums cfg_len consecutive 8-lane vectors per frame, then applies a rounded arithmetic right shift.
- Saturates each lane to OW bits and presents one 8-lane result per frame on a valid/ready output.

---
 rtl/ch8_accum_sat_if.sv | 19 +
 rtl/ch8_accum_sat.sv | 154 +++++++++++++++
 tb/tb_ch8_accum_sat.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ch8_accum_sat_if.sv
// Stream bundle for the 8-lane frame accumulator: input vector handshake and
// per-frame result handshake.
interface ch8_accum_sat_if #(
  parameter int DW = 8,
  parameter int OW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0][DW-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0][OW-1:0]   out_data;
  logic [7:0]           out_ovf;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_ovf);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/ch8_accum_sat.sv
// 8-channel signed frame accumulator: sums cfg_len vectors, rounds by cfg_shift,
// saturates each lane to OW bits and holds the result until it is taken.
module ch8_accum_lane #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beat,
  input  logic          first,
  input  logic          last,
  input  logic          clear,
  input  logic [3:0]    shift,
  input  logic [DW-1:0] din,
  output logic [OW-1:0] dout,
  output logic          ovf
);
  localparam logic [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  logic [AW-1:0]        acc, sum_sat;
  logic                 sticky, sticky_eff, ov_acc, ov_out;
  logic signed [AW:0]   base_x, din_x, sum_w, rnd, rsum, r;
  logic [OW-1:0]        sat_out;

  // One guard bit above AW catches accumulator overflow and keeps the
  // rounding add exact.
  always_comb begin
    base_x     = first ? '0 : {acc[AW-1], acc};
    din_x      = {{(AW+1-DW){din[DW-1]}}, din};
    sum_w      = base_x + din_x;
    ov_acc     = sum_w[AW] != sum_w[AW-1];
    sum_sat    = ov_acc ? (sum_w[AW] ? AMIN : AMAX) : sum_w[AW-1:0];
    rnd        = (shift == 4'd0) ? '0 : ((AW+1)'(1) << (shift - 4'd1));
    rsum       = {sum_sat[AW-1], sum_sat} + rnd;
    r          = rsum >>> shift;
    ov_out     = ~((&r[AW:OW-1]) | ~(|r[AW:OW-1]));
    sat_out    = ov_out ? (r[AW] ? OMIN : OMAX) : r[OW-1:0];
    sticky_eff = ~first & sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sticky <= 1'b0;
      dout   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (clear) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else if (beat) begin
        acc    <= sum_sat;
        sticky <= sticky_eff | ov_acc;
      end
      if (beat && last) begin
        dout <= sat_out;
        ovf  <= sticky_eff | ov_acc | ov_out;
      end
    end
  end
endmodule

module ch8_accum_sat #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int OW    = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [3:0]       cfg_shift,
  ch8_accum_sat_if.slave   bus,
  output logic             busy
);
  localparam int NUM_LANES = 8;

  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nxt;

  logic [LEN_W-1:0] count, len_q, eff_len;
  logic [3:0]       shift_q, eff_shift;
  logic             beat, first, last, xfer;
  logic [NUM_LANES-1:0][OW-1:0] lane_data;
  logic [NUM_LANES-1:0]         lane_ovf;

  // The first beat of a frame uses the live config; later beats use the latched copy.
  always_comb begin
    beat      = bus.in_valid && bus.in_ready;
    first     = (count == '0);
    eff_len   = first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
    eff_shift = first ? cfg_shift : shift_q;
    last      = (count == eff_len - LEN_W'(1));
    xfer      = bus.out_valid && bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (beat && last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ACC);
    bus.out_valid = (state == HOLD);
    busy          = (state == HOLD) || (count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      len_q   <= '0;
      shift_q <= '0;
    end else if (beat) begin
      if (first) begin
        len_q   <= eff_len;
        shift_q <= cfg_shift;
      end
      count <= last ? '0 : count + LEN_W'(1);
    end else if (xfer) begin
      count <= '0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ch8_accum_lane #(.DW(DW), .AW(AW), .OW(OW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .beat  (beat),
      .first (first),
      .last  (last),
      .clear (xfer),
      .shift (eff_shift),
      .din   (bus.in_data[g]),
      .dout  (lane_data[g]),
      .ovf   (lane_ovf[g])
    );
  end

  assign bus.out_data = lane_data;
  assign bus.out_ovf  = lane_ovf;
endmodule

// File: tb/tb_ch8_accum_sat.sv
// Directed plus randomized frames for ch8_accum_sat, checked against an
// integer-arithmetic frame model.
module tb_ch8_accum_sat;
  localparam int DW = 8, AW = 16, OW = 8, LEN_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_len;
  logic [3:0] cfg_shift;
  logic       busy;

  ch8_accum_sat_if #(.DW(DW), .OW(OW)) bus ();

  ch8_accum_sat #(.DW(DW), .AW(AW), .OW(OW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int beats[256][8];
  logic [7:0][7:0] exp_d, got_d;
  logic [7:0]      exp_o, got_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame result straight from the arithmetic definition.
  task automatic model(input int nb, input int sh);
    for (int l = 0; l < 8; l++) begin
      int acc = 0;
      int r;
      bit st = 1'b0;
      for (int b = 0; b < nb; b++) begin
        acc += beats[b][l];
        if (acc > 32767)       begin acc = 32767;  st = 1'b1; end
        else if (acc < -32768) begin acc = -32768; st = 1'b1; end
      end
      r = (acc + ((sh > 0) ? (1 << (sh - 1)) : 0)) >>> sh;
      if (r > 127)       begin r = 127;  st = 1'b1; end
      else if (r < -128) begin r = -128; st = 1'b1; end
      exp_d[l] = r[7:0];
      exp_o[l] = st;
    end
  endtask

  task automatic run_frame(input int lcfg, input int sh, input int hold, input bit gaps);
    int nb;
    nb = (lcfg == 0) ? 1 : lcfg;
    model(nb, sh);
    cfg_len   = lcfg[7:0];
    cfg_shift = sh[3:0];
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        tick;
      end
      chk("in_ready_acc", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      for (int l = 0; l < 8; l++) bus.in_data[l] = beats[b][l][7:0];
      tick;
      if (b == 0 && gaps) begin
        cfg_len   = 8'($urandom);
        cfg_shift = 4'($urandom);
      end
      if (b != nb - 1) chk("busy_mid", busy, 1);
    end
    chk("out_valid_lat1", bus.out_valid, 1);
    got_d = bus.out_data;
    got_o = bus.out_ovf;
    chk("out_data", got_d, exp_d);
    chk("out_ovf", got_o, exp_o);
    chk("in_ready_hold", bus.in_ready, 0);
    chk("busy_hold", busy, 1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      tick;
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, got_d);
      chk("bp_ovf", bus.out_ovf, got_o);
      chk("bp_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("post_valid", bus.out_valid, 0);
    chk("post_ready", bus.in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_data_kept", bus.out_data, got_d);
  endtask

  task automatic fill(input int nb, input int v);
    for (int b = 0; b < nb; b++)
      for (int l = 0; l < 8; l++) beats[b][l] = v;
  endtask

  initial begin
    rst = 1'b1; cfg_len = '0; cfg_shift = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_busy", busy, 0);

    fill(4, 10);
    run_frame(4, 2, 0, 1'b0);
    chk("basic_const", got_d, {8{8'd10}});
    chk("basic_ovf", got_o, 0);

    fill(2, 0);
    beats[0][0] = -3; beats[1][0] = -4;
    beats[0][1] = 3;  beats[1][1] = 4;
    run_frame(2, 1, 1, 1'b0);
    chk("neg_round_l0", got_d[0], 8'hFD);
    chk("neg_round_l1", got_d[1], 8'd4);
    chk("neg_round_ovf", got_o, 0);

    fill(4, 0);
    for (int b = 0; b < 4; b++) begin beats[b][2] = 127; beats[b][5] = -128; end
    run_frame(4, 0, 0, 1'b0);
    chk("sat_ovf", got_o, 8'h24);
    chk("sat_l2", got_d[2], 8'h7F);
    chk("sat_l5", got_d[5], 8'h80);
    chk("sat_l0", got_d[0], 8'h00);

    for (int b = 0; b < 3; b++)
      for (int l = 0; l < 8; l++) beats[b][l] = int'($urandom_range(0, 255)) - 128;
    run_frame(3, 1, 5, 1'b0);

    fill(3, 7);
    run_frame(3, 0, 0, 1'b1);
    chk("latch_len3", got_d, {8{8'd21}});

    fill(1, 5);
    run_frame(0, 0, 0, 1'b0);
    chk("len0_const", got_d, {8{8'd5}});

    cfg_len = 8'd4; cfg_shift = 4'd0;
    bus.in_valid = 1'b1; bus.in_data = {8{8'd50}};
    tick; tick;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.in_ready, 1);
    fill(4, 1);
    run_frame(4, 0, 0, 1'b0);
    chk("midrst_sum", got_d, {8{8'd4}});

    fill(255, 127);
    run_frame(255, 7, 0, 1'b0);
    chk("long_ovf", got_o, 8'hFF);

    repeat (40) begin
      int len, sh;
      len = $urandom_range(0, 6);
      sh  = $urandom_range(0, 15);
      for (int b = 0; b < 6; b++)
        for (int l = 0; l < 8; l++) beats[b][l] = int'($urandom_range(0, 255)) - 128;
      run_frame(len, sh, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
